sign_magnitude_to_twos: RTL

- Bit-serial converter from sign-magnitude to two's complement. It is the inverse of the magnitude extractor that turns a two's-complement value into its absolute value.
- Accepts a W-bit magnitude plus a sign bit over a valid/ready handshake.
- Produces the W-bit two's-complement result LSB-first, using one carry flip-flop and one bit per clock. Flags values that cannot be represented.
- Sits downstream of the calculator datapath, where results held as sign + magnitude are re-encoded before storage or display.

---
 rtl/sign_magnitude_to_twos_pkg.sv | 13 +
 rtl/sign_magnitude_to_twos_if.sv | 22 ++
 rtl/sign_magnitude_to_twos_negate_bit.sv | 11 +
 rtl/sign_magnitude_to_twos.sv | 70 +++++++
 4 files changed

// File: rtl/sign_magnitude_to_twos_pkg.sv
// Shared types and sizing helpers for the serial sign-magnitude to two's-complement converter.
package sign_magnitude_to_twos_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int DATA_W = 8;

  // Bit counter width; the extra bit keeps the count unambiguous for powers of two.
  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/sign_magnitude_to_twos_if.sv
// Input/output handshake bundle for the converter; slave is the converter side.
interface sign_magnitude_to_twos_if #(parameter int W = 8);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] mag;
  logic         sign;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         overflow;
  logic         busy;

  modport slave (
    input  in_valid, mag, sign, out_ready,
    output in_ready, out_valid, result, overflow, busy
  );

  modport master (
    output in_valid, mag, sign, out_ready,
    input  in_ready, out_valid, result, overflow, busy
  );
endinterface

// File: rtl/sign_magnitude_to_twos_negate_bit.sv
// One-bit serial negate cell: passes the bit through when positive, else ~bit + carry.
module serial_negate_bit (
  input  logic m_bit,
  input  logic sign,
  input  logic carry_in,
  output logic out_bit,
  output logic carry_out
);
  assign out_bit   = sign ? (~m_bit ^ carry_in) : m_bit;
  assign carry_out = sign ? (~m_bit & carry_in) : carry_in;
endmodule

// File: rtl/sign_magnitude_to_twos.sv
// Bit-serial sign-magnitude to two's-complement converter, LSB first, one bit per clock.
module sign_magnitude_to_twos
  import sign_magnitude_to_twos_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  sign_magnitude_to_twos_if.slave   bus
);
  localparam int CW = cnt_w(W);

  state_t        state;
  logic [W-1:0]  m;
  logic [W-1:0]  res;
  logic          s;
  logic          carry;
  logic          ovf;
  logic [CW-1:0] cnt;
  logic          b;
  logic          carry_nx;

  serial_negate_bit u_neg (
    .m_bit    (m[0]),
    .sign     (s),
    .carry_in (carry),
    .out_bit  (b),
    .carry_out(carry_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      m     <= '0;
      res   <= '0;
      s     <= 1'b0;
      carry <= 1'b0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          m     <= bus.mag;
          s     <= bus.sign;
          carry <= 1'b1;
          cnt   <= '0;
          // Negative side reaches one further: -2^(W-1) is representable.
          ovf   <= bus.sign ? (bus.mag[W-1] & (|bus.mag[W-2:0])) : bus.mag[W-1];
          state <= SHIFT;
        end
        SHIFT: begin
          m     <= m >> 1;
          res   <= {b, res[W-1:1]};
          carry <= carry_nx;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(W-1)) state <= DONE;
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.result    = res;
  assign bus.overflow  = ovf;

endmodule
